key_mask_filter: RTL

- Streaming stage directly downstream of the green-screen keyer.
- Keyed pixels arrive as RGB = 0,0,0. The block removes speckle from the key mask with a horizontal majority vote over a WIN-pixel window, confined to a single line.
- Voted-keyed pixels are replaced with a programmable background colour; all other pixels pass through unchanged.
- Output feeds the VGA composite path.

---
 rtl/key_filter_pkg.sv | 31 +++
 rtl/key_vote.sv | 36 +++
 rtl/key_mask_filter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the key-mask speckle filter.
package key_filter_pkg;

    // One window slot: the pixel plus the bookkeeping needed for voting.
    typedef struct packed {
        logic        valid;
        logic        keyed;
        logic [23:0] rgb;
        logic        tag;
        logic        eol;
    } slot_t;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } state_e;

    // The keyer marks keyed pixels as pure black.
    function automatic logic is_keyed(input logic [23:0] rgb);
        return rgb == 24'd0;
    endfunction

    function automatic int unsigned half_of(input int unsigned win);
        return (win - 1) / 2;
    endfunction

    function automatic int unsigned count_width(input int unsigned win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/key_vote.sv
// Combinational majority vote over the window, restricted to slots of the
// centre pixel's line.
module key_vote
    import key_filter_pkg::*;
#(
    parameter int unsigned WIN = 5
) (
    input  logic [WIN-1:0] valid,
    input  logic [WIN-1:0] keyed,
    input  logic [WIN-1:0] tag,
    output logic           keep_bg
);

    localparam int unsigned HALF = half_of(WIN);
    localparam int unsigned CW   = count_width(WIN);

    logic [CW-1:0] k_cnt;
    logic [CW-1:0] m_cnt;

    // Count members (same line as centre) and keyed members, then majority.
    always_comb begin
        k_cnt = '0;
        m_cnt = '0;
        for (int unsigned j = 0; j < WIN; j++) begin
            if (valid[j] && (tag[j] == tag[HALF])) begin
                m_cnt = m_cnt + CW'(1);
                if (keyed[j]) begin
                    k_cnt = k_cnt + CW'(1);
                end
            end
        end
        // Even member count with an exact tie resolves to "not keyed".
        keep_bg = {k_cnt, 1'b0} > {1'b0, m_cnt};
    end

endmodule

// File: rtl/key_mask_filter.sv
// Horizontal majority filter on the keyer's mask; voted-keyed pixels are
// replaced by the background colour, everything else passes through.
module key_mask_filter
    import key_filter_pkg::*;
#(
    parameter int unsigned WIN       = 5,
    parameter bit          LAT_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sol,
    input  logic       in_eol,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic [7:0] bg_r,
    input  logic [7:0] bg_g,
    input  logic [7:0] bg_b,
    output logic       out_valid,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_eol
);

    localparam int unsigned HALF = half_of(WIN);
    localparam int unsigned DCW  = $clog2(HALF + 2);

    state_e               state_q, state_d;
    logic [DCW-1:0]       cnt_q, cnt_d;
    logic                 tag_q;

    // Slots 0..HALF carry full pixels; older slots only need their vote
    // fields because their payload has already been emitted.
    slot_t [HALF:0]       head_q;
    logic  [WIN-1:HALF+1] tail_valid_q;
    logic  [WIN-1:HALF+1] tail_keyed_q;
    logic  [WIN-1:HALF+1] tail_tag_q;

    slot_t                new_slot;
    logic                 accept;
    logic                 adv;
    logic                 fire;
    logic                 keep_bg;
    logic [WIN-1:0]       v_vec, k_vec, t_vec;

    logic                 out_valid_q;
    logic                 out_eol_q;
    logic [23:0]          out_rgb_q;

    assign accept = in_valid & in_ready;
    assign adv    = (state_q == StDrain) | accept;
    assign fire   = adv & head_q[HALF].valid;

    // Build the slot shifted in: the accepted pixel in RUN, a bubble in DRAIN.
    always_comb begin
        new_slot = '0;
        if (state_q == StRun) begin
            new_slot.valid = 1'b1;
            new_slot.keyed = is_keyed({in_r, in_g, in_b});
            new_slot.rgb   = {in_r, in_g, in_b};
            new_slot.tag   = tag_q ^ in_sol;
            new_slot.eol   = in_eol;
        end
    end

    // Line tag toggles on every start-of-line so lines never vote together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= 1'b0;
        end else if (accept) begin
            tag_q <= tag_q ^ in_sol;
        end
    end

    // Window shift register, advancing only on adv.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_valid_q <= '0;
            tail_keyed_q <= '0;
            tail_tag_q   <= '0;
        end else if (adv) begin
            for (int unsigned i = HALF; i > 0; i--) begin
                head_q[i] <= head_q[i-1];
            end
            head_q[0] <= new_slot;
            for (int unsigned i = WIN - 1; i > HALF + 1; i--) begin
                tail_valid_q[i] <= tail_valid_q[i-1];
                tail_keyed_q[i] <= tail_keyed_q[i-1];
                tail_tag_q[i]   <= tail_tag_q[i-1];
            end
            tail_valid_q[HALF+1] <= head_q[HALF].valid;
            tail_keyed_q[HALF+1] <= head_q[HALF].keyed;
            tail_tag_q[HALF+1]   <= head_q[HALF].tag;
        end
    end

    // Flatten the vote fields of the pre-shift window.
    always_comb begin
        v_vec = '0;
        k_vec = '0;
        t_vec = '0;
        for (int unsigned i = 0; i <= HALF; i++) begin
            v_vec[i] = head_q[i].valid;
            k_vec[i] = head_q[i].keyed;
            t_vec[i] = head_q[i].tag;
        end
        for (int unsigned i = HALF + 1; i < WIN; i++) begin
            v_vec[i] = tail_valid_q[i];
            k_vec[i] = tail_keyed_q[i];
            t_vec[i] = tail_tag_q[i];
        end
    end

    key_vote #(
        .WIN (WIN)
    ) u_key_vote (
        .valid   (v_vec),
        .keyed   (k_vec),
        .tag     (t_vec),
        .keep_bg (keep_bg)
    );

    // FSM state and drain counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: drain HALF+1 bubbles after each end-of-line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (accept && in_eol) begin
                    state_d = StDrain;
                    cnt_d   = DCW'(HALF + 1);
                end
            end
            StDrain: begin
                if (cnt_q == DCW'(1)) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - DCW'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs: accept input only while running.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == StRun) begin
            in_ready = 1'b1;
        end
    end

    // Output register; rgb holds its last value when nothing is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            out_valid_q <= fire;
            out_eol_q   <= fire & head_q[HALF].eol;
            if (fire) begin
                out_rgb_q <= keep_bg ? {bg_r, bg_g, bg_b} : head_q[HALF].rgb;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_r     = out_rgb_q[23:16];
    assign out_g     = out_rgb_q[15:8];
    assign out_b     = out_rgb_q[7:0];

`ifndef SYNTHESIS
    if (LAT_CHECK) begin : g_checks
        win_odd_a: assert property (@(posedge clk) (WIN % 2 == 1) && (WIN >= 3));
        // A stalled pixel must be held by upstream until accepted.
        hold_a: assert property (@(posedge clk) disable iff (rst)
            (in_valid && !in_ready) |=> in_valid);
    end
`endif

endmodule
